player_sprite_fetch: RTL and testbench

- Read-side client of the player sprite RAM: converts the VGA scan position into sprite RAM read addresses.
- Consumes the RAM's registered read data and emits a palette index plus an opaque/visible flag, aligned through a fixed pipeline.
- Sits between the VGA controller/position logic and the colour mapper.
- Latches player position once per frame so the sprite never tears mid-frame.

---
 rtl/player_sprite_fetch.sv | 70 +++++++
 tb/tb_player_sprite_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/player_sprite_fetch.sv
// Player sprite read client: maps the VGA scan position onto sprite RAM addresses
// and aligns the RAM's registered data into a palette index with an opaque flag.
module player_sprite_fetch #(
    parameter int SPRITE_W    = 48,
    parameter int SPRITE_H    = 30,
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 5,
    parameter int TRANSPARENT = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_en,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        PlayerX,
    input  logic [9:0]        PlayerY,
    input  logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] read_address,
    output logic              pix_valid,
    output logic              pix_on,
    output logic [DATA_W-1:0] pix_idx
);

    localparam logic signed [10:0] W_S = 11'(SPRITE_W);
    localparam logic signed [10:0] H_S = 11'(SPRITE_H);

    logic [9:0]         sx, sy;
    logic signed [10:0] dx, dy;
    logic               hit0;
    logic [ADDR_W-1:0]  addr0;
    logic               v1, h1, v2, h2;

    // Offsets are signed so pixels left of / above the sprite never alias into it.
    assign dx   = $signed({1'b0, DrawX}) - $signed({1'b0, sx});
    assign dy   = $signed({1'b0, DrawY}) - $signed({1'b0, sy});
    assign hit0 = pix_en && (dx >= 0) && (dx < W_S) && (dy >= 0) && (dy < H_S);

    assign addr0 = ADDR_W'(dy[9:0]) * ADDR_W'(SPRITE_W) + ADDR_W'(dx[9:0]);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx           <= '0;
            sy           <= '0;
            read_address <= '0;
            v1           <= 1'b0;
            h1           <= 1'b0;
            v2           <= 1'b0;
            h2           <= 1'b0;
        end else begin
            // Position shadow only moves at frame start so a frame never tears.
            if (frame_start) begin
                sx <= PlayerX;
                sy <= PlayerY;
            end
            read_address <= hit0 ? addr0 : '0;
            v1           <= pix_en;
            h1           <= hit0;
            v2           <= v1;
            h2           <= h1;
        end
    end

    // pix_valid qualifies pix_on/pix_idx two clocks after pix_en; there is no
    // ready, the pipeline never stalls and pix_en gaps come out as bubbles.
    assign pix_valid = v2;
    assign pix_on    = v2 & h2 & (ram_data != DATA_W'(TRANSPARENT));
    assign pix_idx   = pix_on ? ram_data : '0;

endmodule

// File: tb/tb_player_sprite_fetch.sv
// Bench for player_sprite_fetch: directed pixels with hand-computed addresses and
// palette results, checked by a cycle-tagged scoreboard monitor.
module tb_player_sprite_fetch;

    typedef struct packed {
        int          due;
        logic [18:0] addr;
    } addr_exp_t;

    typedef struct packed {
        int         due;
        logic [6:0] val;   // {valid, on, idx}
    } pix_exp_t;

    logic        clk;
    logic        rst_n;
    logic        pix_en;
    logic        frame_start;
    logic [9:0]  draw_x, draw_y, player_x, player_y;
    logic [4:0]  ram_data;
    logic [18:0] read_address;
    logic        pix_valid, pix_on;
    logic [4:0]  pix_idx;

    logic [4:0]  mem [0:1439];
    addr_exp_t   addr_q[$];
    pix_exp_t    pix_q[$];
    int          cyc;
    int          n_checks;
    int          n_fail;

    player_sprite_fetch dut (
        .Clk          (clk),
        .Reset_n      (rst_n),
        .pix_en       (pix_en),
        .frame_start  (frame_start),
        .DrawX        (draw_x),
        .DrawY        (draw_y),
        .PlayerX      (player_x),
        .PlayerY      (player_y),
        .ram_data     (ram_data),
        .read_address (read_address),
        .pix_valid    (pix_valid),
        .pix_on       (pix_on),
        .pix_idx      (pix_idx)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model with one cycle of registered read latency
    always @(posedge clk) begin
        if (read_address < 19'd1440) ram_data <= mem[read_address[10:0]];
        else                         ram_data <= 5'h1f;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver: present one scan cycle and queue its expected address and pixel
    task automatic drive(input logic pen, input logic fs,
                         input logic [9:0] x, input logic [9:0] y,
                         input logic [9:0] px, input logic [9:0] py,
                         input logic [18:0] ea,
                         input logic ev, input logic eo, input logic [4:0] ei);
        @(negedge clk);
        pix_en      = pen;
        frame_start = fs;
        draw_x      = x;
        draw_y      = y;
        player_x    = px;
        player_y    = py;
        addr_q.push_back('{due: cyc + 1, addr: ea});
        pix_q.push_back('{due: cyc + 2, val: {ev, eo, ei}});
    endtask

    // scoreboard monitor, sampling 2 time units after each rising edge
    always @(posedge clk) begin
        #2;
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            addr_exp_t ea;
            ea = addr_q.pop_front();
            check("read_address", 32'(read_address), 32'(ea.addr));
        end
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pix_exp_t ep;
            ep = pix_q.pop_front();
            check("pix_out", 32'({pix_valid, pix_on, pix_idx}), 32'(ep.val));
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 1440; i++) mem[i] = 5'd3;
        mem[0]    = 5'd5;
        mem[1439] = 5'd9;
        mem[250]  = 5'd0;
        mem[252]  = 5'd17;
        mem[253]  = 5'd22;

        rst_n = 1'b0; pix_en = 1'b0; frame_start = 1'b0;
        draw_x = '0; draw_y = '0; player_x = '0; player_y = '0;

        // 1. reset with pix_en toggling: everything held at zero
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pix_en = ~pix_en;
            @(posedge clk); #2;
            check("rst_addr",  32'(read_address), 32'd0);
            check("rst_valid", 32'(pix_valid),    32'd0);
            check("rst_on",    32'(pix_on),       32'd0);
            check("rst_idx",   32'(pix_idx),      32'd0);
        end
        @(negedge clk);
        pix_en = 1'b0;
        rst_n  = 1'b1;

        // shadow still (0,0): pixel (0,0) hits mem[0]=5
        drive(1, 0,   0,   0,   0,   0,    0, 1, 1, 5);
        // 2. latch (300,400) then top-left corner
        drive(0, 1,   0,   0, 300, 400,    0, 0, 0, 0);
        drive(1, 0, 300, 400, 300, 400,    0, 1, 1, 5);
        // 3. boundaries
        drive(1, 0, 347, 429, 300, 400, 1439, 1, 1, 9);
        drive(1, 0, 348, 429, 300, 400,    0, 1, 0, 0);
        drive(1, 0, 299, 400, 300, 400,    0, 1, 0, 0);
        drive(1, 0, 300, 399, 300, 400,    0, 1, 0, 0);
        drive(1, 0, 300, 430, 300, 400,    0, 1, 0, 0);
        // 4. transparent texel inside the sprite
        drive(1, 0, 310, 405, 300, 400,  250, 1, 0, 0);
        // 5. shadow timing
        drive(1, 0, 300, 400, 100, 400,    0, 1, 1, 5);
        drive(1, 1, 300, 400, 100, 400,    0, 1, 1, 5);
        drive(1, 0, 300, 400, 100, 400,    0, 1, 0, 0);
        drive(1, 0, 101, 401, 100, 400,   49, 1, 1, 3);
        drive(0, 1,   0,   0, 300, 400,    0, 0, 0, 0);
        // 6. streaming with a bubble
        drive(1, 0, 310, 405, 300, 400,  250, 1, 0, 0);
        drive(0, 0, 311, 405, 300, 400,    0, 0, 0, 0);
        drive(1, 0, 312, 405, 300, 400,  252, 1, 1, 17);
        drive(1, 0, 313, 405, 300, 400,  253, 1, 1, 22);
        // sprite hanging off the bottom-right: no wrap to the far side
        drive(0, 1,   0,   0, 620, 470,    0, 0, 0, 0);
        drive(1, 0, 639, 479, 620, 470,  451, 1, 1, 3);
        drive(1, 0,   0,   0, 620, 470,    0, 1, 0, 0);
        drive(1, 0,  10,   5, 620, 470,    0, 1, 0, 0);
        drive(0, 0,   0,   0, 620, 470,    0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // reset asserted with a hit pixel in flight
        pix_en = 1'b1; draw_x = 10'd639; draw_y = 10'd479;
        @(posedge clk); #2;
        check("midrst_pre_addr", 32'(read_address), 32'd451);
        @(negedge clk);
        pix_en = 1'b0;
        @(posedge clk); #2;
        check("midrst_pre_on", 32'({pix_valid, pix_on, pix_idx}), 32'({1'b1, 1'b1, 5'd3}));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_addr",  32'(read_address), 32'd0);
        check("midrst_valid", 32'(pix_valid),    32'd0);
        check("midrst_on",    32'(pix_on),       32'd0);
        check("midrst_idx",   32'(pix_idx),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // shadow back at (0,0) until the next frame_start
        drive(0, 0,   0,   0, 620, 470,    0, 0, 0, 0);
        drive(1, 0,   0,   0, 620, 470,    0, 1, 1, 5);
        drive(0, 0,   0,   0, 620, 470,    0, 0, 0, 0);
        repeat (4) @(negedge clk);

        check("queue_drain", 32'(addr_q.size() + pix_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
